// File: rtl/dac_duc_pkg.sv
// Shared types, Q1.15 constants and constant functions for the DAC-path upconverter.
// quarter_sin() builds the quarter-wave ROM at elaboration using an integer Taylor series.
package dac_duc_pkg;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic signed [15:0] Q15_MAX    = 16'sd32767;
    localparam logic signed [15:0] Q15_MIN    = -16'sd32768;
    localparam logic signed [32:0] ROUND_HALF = 33'sd16384;
    localparam longint             HALF_PI_FX = 64'sd1686629713;  // pi/2 in Q2.30

    function automatic logic signed [15:0] saturate16(input logic signed [32:0] x);
        if (x > 33'sd32767) return Q15_MAX;
        if (x < -33'sd32768) return Q15_MIN;
        return x[15:0];
    endfunction

    // sin(k/depth * pi/2) in Q1.15; k == depth yields exactly full scale.
    function automatic logic [15:0] quarter_sin(input int k, input int depth);
        longint x, term, sum, r;
        if (k >= depth) return 16'(Q15_MAX);
        x    = (longint'(k) * HALF_PI_FX) / longint'(depth);
        term = x;
        sum  = x;
        for (int n = 1; n <= 6; n++) begin
            term = -((((term * x) >>> 30) * x) >>> 30) / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        r = ((sum * 64'sd32767) + (64'sd1 <<< 29)) >>> 30;
        if (r > 64'sd32767) r = 64'sd32767;
        if (r < 64'sd0) r = 64'sd0;
        return r[15:0];
    endfunction

endpackage

// File: rtl/dac_duc_tx_nco.sv
// Phase-accumulator NCO with a quarter-wave sine ROM; cos/sin registered one cycle after advance.
// The sample uses the phase before the increment, so the first sample after clear is phase 0.
module tx_nco_lut
    import dac_duc_pkg::*;
#(
    parameter int LUT_ABITS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               advance,
    input  logic [31:0]        fc_inc,
    output logic signed [15:0] cos_q,
    output logic signed [15:0] sin_q
);

    localparam int DEPTH = 1 << LUT_ABITS;

    logic [15:0]          rom [DEPTH+1];
    logic [31:0]          phase_q, phase_d;
    logic signed [15:0]   cos_d, sin_d;
    logic [1:0]           quad;
    logic [LUT_ABITS:0]   addr_fwd, addr_rev;
    logic signed [15:0]   s_fwd, s_rev;

    for (genvar k = 0; k <= DEPTH; k++) begin : g_rom
        assign rom[k] = quarter_sin(k, DEPTH);
    end

    assign quad     = phase_q[31:30];
    assign addr_fwd = {1'b0, phase_q[29:30-LUT_ABITS]};
    assign addr_rev = (LUT_ABITS+1)'(DEPTH) - addr_fwd;
    assign s_fwd    = rom[addr_fwd];
    assign s_rev    = rom[addr_rev];

    // Quadrant folding: cos(t) = sin(90deg - t) reads the ROM mirrored.
    always_comb begin
        phase_d = phase_q;
        cos_d   = cos_q;
        sin_d   = sin_q;
        if (clear) begin
            phase_d = '0;
            cos_d   = '0;
            sin_d   = '0;
        end else if (advance) begin
            phase_d = phase_q + fc_inc;
            case (quad)
                2'd0: begin sin_d = s_fwd;  cos_d = s_rev;  end
                2'd1: begin sin_d = s_rev;  cos_d = -s_fwd; end
                2'd2: begin sin_d = -s_fwd; cos_d = -s_rev; end
                default: begin sin_d = -s_rev; cos_d = s_fwd; end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
            cos_q   <= '0;
            sin_q   <= '0;
        end else begin
            phase_q <= phase_d;
            cos_q   <= cos_d;
            sin_q   <= sin_d;
        end
    end

endmodule

// File: rtl/dac_duc_tx.sv
// Transmit upconverter: AXI-Stream I/Q in, held interp_ratio DAC samples, mixed with an NCO carrier.
// Beat accepted when S_AXIS_tvalid & S_AXIS_tready are both high on a rising aclk edge.
module dac_duc_tx
    import dac_duc_pkg::*;
#(
    parameter int SAMPLE_DIV    = 10,
    parameter int LUT_ABITS     = 8,
    parameter int OFFSET_BINARY = 0
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [31:0] S_AXIS_tdata,
    input  logic        S_AXIS_tvalid,
    output logic        S_AXIS_tready,
    input  logic [31:0] Fc_scaled,
    input  logic [15:0] interp_ratio,
    input  logic [3:0]  DAC_control,
    output logic [15:0] DACdata,
    output logic        dac_strobe,
    output logic [31:0] status
);

    localparam int              DIV_W    = $clog2(SAMPLE_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [15:0]     MSB_FLIP = (OFFSET_BINARY != 0) ? 16'h8000 : 16'h0000;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [15:0]         hold_q, hold_d;
    logic [31:0]         skid_q, skid_d;
    logic                skid_full_q, skid_full_d;
    logic [31:0]         samp_q, samp_d;
    logic [31:0]         fc_q, fc_d;
    logic                v1_q, v1_d, v2_q, v2_d;
    logic signed [31:0]  prod_re_q, prod_re_d, prod_im_q, prod_im_d;
    logic [15:0]         dac_q, dac_d;
    logic                strobe_q, strobe_d;
    logic [15:0]         uf_cnt_q, uf_cnt_d;
    logic                sticky_q, sticky_d;

    logic                enable, run, active, tick, consume, underflow, beat_hs, nco_clear;
    logic signed [15:0]  cos_q, sin_q, samp_re, samp_im, mix_sat;
    logic signed [32:0]  mix_sum, mix_shr;
    logic [1:0]          ctrl_rsvd_unused;

    assign enable           = DAC_control[0];
    assign ctrl_rsvd_unused = DAC_control[3:2];
    assign run              = (state_q == RUN);
    assign active           = run & enable;
    assign tick             = active & (div_q == DIV_LAST);
    assign consume          = tick & (hold_q == 16'd0);
    assign underflow        = consume & ~skid_full_q;
    assign S_AXIS_tready    = run & ~skid_full_q;
    assign beat_hs          = S_AXIS_tvalid & S_AXIS_tready;
    assign nco_clear        = ~active;

    tx_nco_lut #(.LUT_ABITS(LUT_ABITS)) u_nco (
        .clk     (aclk),
        .rst     (areset),
        .clear   (nco_clear),
        .advance (tick),
        .fc_inc  (fc_d),
        .cos_q   (cos_q),
        .sin_q   (sin_q)
    );

    assign samp_re   = samp_q[15:0];
    assign samp_im   = samp_q[31:16];
    assign prod_re_d = 32'(samp_re) * 32'(cos_q);
    assign prod_im_d = 32'(samp_im) * 32'(sin_q);
    assign mix_sum   = $signed({prod_re_q[31], prod_re_q}) - $signed({prod_im_q[31], prod_im_q}) + ROUND_HALF;
    assign mix_shr   = mix_sum >>> 15;
    assign mix_sat   = saturate16(mix_shr);

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        hold_d      = hold_q;
        skid_d      = skid_q;
        skid_full_d = skid_full_q;
        samp_d      = samp_q;
        fc_d        = fc_q;
        v1_d        = 1'b0;
        v2_d        = 1'b0;
        strobe_d    = 1'b0;
        dac_d       = dac_q;
        uf_cnt_d    = uf_cnt_q;
        sticky_d    = sticky_q;

        if (!run && enable) state_d = RUN;
        else if (run && !enable) state_d = IDLE;

        if (active) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
            // Fc and interp_ratio are latched only when a new beat takes over.
            if (consume) begin
                samp_d      = skid_full_q ? skid_q : 32'd0;
                skid_full_d = 1'b0;
                hold_d      = (interp_ratio == 16'd0) ? 16'd0 : interp_ratio - 16'd1;
                fc_d        = Fc_scaled;
            end else if (tick) begin
                hold_d = hold_q - 16'd1;
            end
            if (beat_hs) begin
                skid_d      = S_AXIS_tdata;
                skid_full_d = 1'b1;
            end
            v1_d     = tick;
            v2_d     = v1_q;
            strobe_d = v2_q;
            if (v2_q) dac_d = mix_sat ^ MSB_FLIP;
        end else begin
            div_d       = '0;
            hold_d      = '0;
            skid_full_d = 1'b0;
            samp_d      = '0;
            fc_d        = '0;
        end
        if (!run) dac_d = MSB_FLIP;

        if (underflow && uf_cnt_q != 16'hFFFF) uf_cnt_d = uf_cnt_q + 16'd1;
        if (underflow) sticky_d = 1'b1;
        if (DAC_control[1]) begin
            uf_cnt_d = '0;
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= IDLE;
            div_q       <= '0;
            hold_q      <= '0;
            skid_q      <= '0;
            skid_full_q <= 1'b0;
            samp_q      <= '0;
            fc_q        <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            prod_re_q   <= '0;
            prod_im_q   <= '0;
            dac_q       <= MSB_FLIP;
            strobe_q    <= 1'b0;
            uf_cnt_q    <= '0;
            sticky_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            hold_q      <= hold_d;
            skid_q      <= skid_d;
            skid_full_q <= skid_full_d;
            samp_q      <= samp_d;
            fc_q        <= fc_d;
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            prod_re_q   <= prod_re_d;
            prod_im_q   <= prod_im_d;
            dac_q       <= dac_d;
            strobe_q    <= strobe_d;
            uf_cnt_q    <= uf_cnt_d;
            sticky_q    <= sticky_d;
        end
    end

    assign DACdata    = dac_q;
    assign dac_strobe = strobe_q;
    assign status     = {14'd0, sticky_q, run, uf_cnt_q};

endmodule

// File: tb/tb_dac_duc_tx.sv
// Directed bench for dac_duc_tx: DC, quarter rotation, saturation, interpolation, underflow, stop/reset.
// Expected words follow y = (I*cos - Q*sin + 2^14) >>> 15, e.g. 16384*32767 + 2^14 = 2^29 -> 0x4000.
module tb_dac_duc_tx;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic [31:0] fc;
    logic [15:0] interp;
    logic [3:0]  ctrl;
    logic [15:0] dac_data;
    logic        dac_strobe;
    logic [31:0] status;

    int          n_checks = 0;
    int          n_fail   = 0;
    time         t_en;
    logic [31:0] beat_q[$];
    logic [15:0] obs_q[$];
    time         obs_t[$];
    time         hs_t[$];
    logic [15:0] exp_q[$];

    dac_duc_tx dut (
        .aclk          (aclk),
        .areset        (areset),
        .S_AXIS_tdata  (tdata),
        .S_AXIS_tvalid (tvalid),
        .S_AXIS_tready (tready),
        .Fc_scaled     (fc),
        .interp_ratio  (interp),
        .DAC_control   (ctrl),
        .DACdata       (dac_data),
        .dac_strobe    (dac_strobe),
        .status        (status)
    );

    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    // Stream driver: presents the queue head and pops it on an accepted beat.
    initial begin
        logic hs;
        tvalid = 1'b0;
        tdata  = '0;
        forever begin
            @(negedge aclk);
            tvalid = (beat_q.size() > 0);
            tdata  = (beat_q.size() > 0) ? beat_q[0] : 32'd0;
            #1;
            hs = tvalid && tready;
            @(posedge aclk);
            if (hs) begin
                void'(beat_q.pop_front());
                hs_t.push_back($time);
            end
        end
    end

    initial begin
        forever begin
            @(negedge aclk);
            if (dac_strobe) begin
                obs_q.push_back(dac_data);
                obs_t.push_back($time);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push_beats(input logic [31:0] b, input int n);
        for (int i = 0; i < n; i++) beat_q.push_back(b);
    endtask

    task automatic start_run(input logic [31:0] f, input logic [15:0] r);
        @(negedge aclk);
        fc     = f;
        interp = r;
        ctrl   = 4'b0001;
        t_en   = $time;
    endtask

    task automatic stop_run();
        @(negedge aclk);
        ctrl = 4'b0000;
        repeat (3) @(negedge aclk);
        beat_q.delete();
        obs_q.delete();
        obs_t.delete();
        hs_t.delete();
        exp_q.delete();
    endtask

    task automatic collect(input int n, input string tag);
        int waited = 0;
        while (obs_q.size() < n && waited < 2000) begin
            @(posedge aclk);
            waited++;
        end
        check_eq({tag, "_strobes"}, 32'(obs_q.size() >= n), 32'd1);
    endtask

    task automatic check_samples(input string tag);
        for (int i = 0; i < exp_q.size(); i++)
            check_eq($sformatf("%s[%0d]", tag, i),
                     (i < obs_q.size()) ? 32'(obs_q[i]) : 32'hDEAD_BEEF, 32'(exp_q[i]));
    endtask

    initial begin
        areset = 1'b1;
        ctrl   = 4'b0000;
        fc     = '0;
        interp = 16'd1;
        repeat (4) @(negedge aclk);
        check_eq("rst_tready", 32'(tready), 32'd0);
        check_eq("rst_dacdata", 32'(dac_data), 32'h0000);
        check_eq("rst_strobe", 32'(dac_strobe), 32'd0);
        check_eq("rst_status", status, 32'h0000_0000);
        areset = 1'b0;
        @(negedge aclk);

        // DC carrier: constant output, 13 clk from enable to first strobe, strobes every 10 clk
        push_beats(32'h0000_4000, 6);
        start_run(32'h0, 16'd1);
        collect(4, "dc");
        exp_q = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
        check_samples("dc");
        check_eq("dc_latency", 32'((obs_t[0] - t_en) / 10), 32'd13);
        check_eq("dc_period", 32'((obs_t[2] - obs_t[1]) / 10), 32'd10);
        stop_run();

        push_beats(32'h0000_4000, 8);
        start_run(32'h4000_0000, 16'd1);
        collect(5, "rot_i");
        exp_q = '{16'h4000, 16'h0000, 16'hC001, 16'h0000, 16'h4000};
        check_samples("rot_i");
        stop_run();

        // interp_ratio 0 must behave as 1
        push_beats(32'h4000_0000, 8);
        start_run(32'h4000_0000, 16'd0);
        collect(4, "rot_q");
        exp_q = '{16'h0000, 16'hC001, 16'h0000, 16'h4000};
        check_samples("rot_q");
        stop_run();

        push_beats(32'h8000_8000, 6);
        start_run(32'h6000_0000, 16'd1);
        collect(3, "sat");
        exp_q = '{16'h8001, 16'h7FFF, 16'h8001};
        check_samples("sat");
        stop_run();

        beat_q = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003};
        start_run(32'h0, 16'd4);
        collect(12, "interp");
        exp_q = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd2, 16'd2, 16'd2, 16'd2, 16'd3, 16'd3, 16'd3, 16'd3};
        check_samples("interp");
        check_eq("interp_hs_count", 32'(hs_t.size()), 32'd3);
        check_eq("interp_hs_gap", 32'((hs_t[2] - hs_t[1]) / 10), 32'd40);
        stop_run();

        @(negedge aclk);
        ctrl = 4'b0010;
        @(negedge aclk);
        ctrl = 4'b0000;
        push_beats(32'h0000_4000, 2);
        start_run(32'h0, 16'd1);
        collect(5, "uflow");
        exp_q = '{16'h4000, 16'h4000, 16'h0000, 16'h0000, 16'h0000};
        check_samples("uflow");
        check_eq("uflow_status", status, 32'h0003_0003);
        @(negedge aclk);
        ctrl = 4'b0011;
        @(negedge aclk);
        ctrl = 4'b0001;
        check_eq("uflow_clear", status, 32'h0001_0000);
        stop_run();

        // Enable drop with the skid empty, then restart from phase 0
        push_beats(32'h0000_4000, 1);
        start_run(32'h4000_0000, 16'd1);
        collect(1, "drop");
        @(negedge aclk);
        check_eq("drop_tready_before", 32'(tready), 32'd1);
        ctrl = 4'b0000;
        @(negedge aclk);
        check_eq("drop_tready_after", 32'(tready), 32'd0);
        @(negedge aclk);
        check_eq("drop_dacdata", 32'(dac_data), 32'h0000);
        check_eq("drop_strobe", 32'(dac_strobe), 32'd0);
        obs_q.delete();
        obs_t.delete();
        push_beats(32'h0000_4000, 8);
        start_run(32'h4000_0000, 16'd1);
        collect(2, "reen");
        exp_q = '{16'h4000, 16'h0000};
        check_samples("reen");

        @(negedge aclk);
        areset = 1'b1;
        @(negedge aclk);
        check_eq("mrst_tready", 32'(tready), 32'd0);
        check_eq("mrst_dacdata", 32'(dac_data), 32'h0000);
        check_eq("mrst_status", status, 32'h0000_0000);
        areset = 1'b0;
        t_en   = $time;
        obs_q.delete();
        obs_t.delete();
        push_beats(32'h0000_4000, 4);
        collect(2, "mrst_run");
        check_samples("mrst_run");
        check_eq("mrst_latency", 32'((obs_t[0] - t_en) / 10), 32'd13);
        stop_run();

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
